// File: rtl/door_ctrl_multi.sv
// door_ctrl_multi: independent per-door open/hold/close FSMs with open count and saturating event counter.
// Optional held-open alarm enabled by DOOR_ALARM_EN; without it doorAlarm is tied to 0.
module door_ctrl_multi #(
   parameter int NUM_DOORS    = 4,
   parameter int MOVE_CYCLES  = 3,
   parameter int HOLD_CYCLES  = 5,
   parameter int ALARM_CYCLES = 32
) (
   input  logic                                 clk,
   input  logic                                 rstN,
   input  logic [NUM_DOORS-1:0]                 doorSen,
   input  logic [NUM_DOORS-1:0]                 obstruct,
   input  logic [NUM_DOORS-1:0]                 lockReq,
   output logic [NUM_DOORS-1:0]                 doorOpen,
   output logic [NUM_DOORS-1:0]                 motorOpen,
   output logic [NUM_DOORS-1:0]                 motorClose,
   output logic [$clog2(NUM_DOORS+1)-1:0]       openCount,
   output logic [15:0]                          eventCnt,
   output logic [NUM_DOORS-1:0]                 doorAlarm
);
   localparam int MAXC = MOVE_CYCLES > HOLD_CYCLES ? MOVE_CYCLES : HOLD_CYCLES;
   localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam int OW = $clog2(NUM_DOORS + 1);
   localparam logic [CW-1:0] MOVE_LD = CW'(MOVE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {CLOSED = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3} doorState_t;

   doorState_t      state     [NUM_DOORS];
   doorState_t      stateNext [NUM_DOORS];
   logic [CW-1:0]   cnt       [NUM_DOORS];
   logic [CW-1:0]   cntNext   [NUM_DOORS];
   logic [4:0]      starts;
   logic [16:0]     eventSum;

   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         for (int i = 0; i < NUM_DOORS; i++) begin
            state[i] <= CLOSED;
            cnt[i]   <= '0;
         end
         eventCnt <= '0;
      end else begin
         for (int i = 0; i < NUM_DOORS; i++) begin
            state[i] <= stateNext[i];
            cnt[i]   <= cntNext[i];
         end
         eventCnt <= eventSum[16] ? 16'hFFFF : eventSum[15:0];
      end

   always_comb begin
      starts = '0;
      for (int i = 0; i < NUM_DOORS; i++) begin
         stateNext[i] = state[i];
         cntNext[i]   = cnt[i];
         case (state[i])
            CLOSED:
               if (doorSen[i] && !lockReq[i]) begin
                  stateNext[i] = OPENING;
                  cntNext[i]   = MOVE_LD;
               end
            OPENING:
               if (cnt[i] == '0) begin
                  stateNext[i] = OPEN;
                  cntNext[i]   = HOLD_LD;
               end else cntNext[i] = cnt[i] - 1'b1;
            OPEN:
               if (doorSen[i] || obstruct[i]) cntNext[i] = HOLD_LD;
               else if (cnt[i] == '0) begin
                  stateNext[i] = CLOSING;
                  cntNext[i]   = MOVE_LD;
               end else cntNext[i] = cnt[i] - 1'b1;
            CLOSING:
               // any activity while closing forces a full re-open
               if (doorSen[i] || obstruct[i]) begin
                  stateNext[i] = OPENING;
                  cntNext[i]   = MOVE_LD;
               end else if (cnt[i] == '0) stateNext[i] = CLOSED;
               else cntNext[i] = cnt[i] - 1'b1;
         endcase
         starts = starts + 5'(state[i] == CLOSED && stateNext[i] == OPENING);
      end
      eventSum = {1'b0, eventCnt} + 17'(starts);
   end

   always_comb begin
      doorOpen   = '0;
      motorOpen  = '0;
      motorClose = '0;
      openCount  = '0;
      for (int i = 0; i < NUM_DOORS; i++) begin
         doorOpen[i]   = state[i] == OPEN;
         motorOpen[i]  = state[i] == OPENING;
         motorClose[i] = state[i] == CLOSING;
         openCount     = openCount + OW'(state[i] == OPEN);
      end
   end

`ifdef DOOR_ALARM_EN
   localparam int AW = $clog2(ALARM_CYCLES + 1);
   localparam logic [AW-1:0] ALARM_AT = AW'(ALARM_CYCLES);

   logic [AW-1:0] alarmCnt [NUM_DOORS];

   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         for (int i = 0; i < NUM_DOORS; i++) alarmCnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_DOORS; i++)
            if (stateNext[i] == CLOSED) alarmCnt[i] <= '0;
            else if (alarmCnt[i] != ALARM_AT) alarmCnt[i] <= alarmCnt[i] + 1'b1;
      end

   always_comb begin
      doorAlarm = '0;
      for (int i = 0; i < NUM_DOORS; i++) doorAlarm[i] = alarmCnt[i] == ALARM_AT;
   end
`else
   assign doorAlarm = '0;
`endif
endmodule

// File: doc/door_ctrl_multi.md
Name: door_ctrl_multi

Overview:
- Parametrised multi-door controller; successor to the single-door combinational opener.
- Each of NUM_DOORS channels runs its own clocked FSM: open on sensor, timed motor travel, hold-open with sensor/obstruction re-arm, timed close, per-door lock.
- Provides aggregate status (doors currently open, saturating open-event counter) to the supervisory/display logic above it.

Parameters:
- NUM_DOORS, 4, number of independent door channels (1..16).
- MOVE_CYCLES, 3, clock cycles of motor travel for a full open or close (>=1).
- HOLD_CYCLES, 5, cycles a door stays fully open after the last sensor/obstruction activity (>=1).
- ALARM_CYCLES, 32, cycles a door may stay away from CLOSED before alarm (used only with DOOR_ALARM_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- doorSen  in  NUM_DOORS  per-door presence sensor, 1 = person detected.
- obstruct  in  NUM_DOORS  per-door obstruction sensor, 1 = blocked.
- lockReq  in  NUM_DOORS  per-door lock, 1 = inhibit opening from CLOSED.
- doorOpen  out  NUM_DOORS  1 = door fully open (state OPEN).
- motorOpen  out  NUM_DOORS  1 = drive motor in open direction (state OPENING).
- motorClose  out  NUM_DOORS  1 = drive motor in close direction (state CLOSING).
- openCount  out  clog2(NUM_DOORS+1)  number of doors currently in OPEN.
- eventCnt  out  16  total CLOSED->OPENING transitions, saturating.
- doorAlarm  out  NUM_DOORS  per-door held-open alarm (see Optional Feature).

Behaviour:
- Single clock domain (clk); rstN is asynchronous, active-low. While rstN=0: every door FSM = CLOSED, counters = 0, doorOpen = motorOpen = motorClose = 0, openCount = 0, eventCnt = 0, doorAlarm = 0. Reset asserted mid-motion aborts immediately to CLOSED.
- Per-door state register (2 bits): CLOSED=0, OPENING=1, OPEN=2, CLOSING=3. Per-door down-counter, width clog2(max(MOVE_CYCLES,HOLD_CYCLES)).
- doorOpen/motorOpen/motorClose are pure decodes of the state register (registered timing, no input-to-output combinational path).
- CLOSED: if doorSen=1 and lockReq=0 -> OPENING, cnt<=MOVE_CYCLES-1. lockReq=1 holds the door CLOSED regardless of doorSen.
- OPENING: if cnt==0 -> OPEN, cnt<=HOLD_CYCLES-1; else cnt--. Inputs ignored (always completes the open).
- OPEN: if doorSen|obstruct -> cnt<=HOLD_CYCLES-1 (stay); else if cnt==0 -> CLOSING, cnt<=MOVE_CYCLES-1; else cnt--. lockReq ignored (lock never traps a person).
- CLOSING: if doorSen|obstruct -> OPENING, cnt<=MOVE_CYCLES-1 (full re-open, safety priority); else if cnt==0 -> CLOSED; else cnt--.
- Latency: doorSen sampled high in CLOSED -> motorOpen high 1 cycle later for exactly MOVE_CYCLES cycles -> doorOpen high for HOLD_CYCLES cycles (no re-arm) -> motorClose MOVE_CYCLES cycles -> CLOSED.
- Channels are fully independent; simultaneous events on several doors are all processed in the same cycle.
- openCount: combinational popcount of doorOpen.
- eventCnt: each cycle adds the number of doors taking CLOSED->OPENING that cycle; clamps at 16'hFFFF (never wraps).

Optional Feature:
- Macro DOOR_ALARM_EN.
- Defined: per-door alarm counter increments every cycle the door is not CLOSED; when it reaches ALARM_CYCLES, doorAlarm[i] sets and stays set (counter stops) until the door returns to CLOSED, which clears counter and alarm the same cycle.
- Undefined: no alarm counters synthesised; doorAlarm port present and tied to 0.

Test Plan:
- Defaults (N=4, MOVE=3, HOLD=5): 1-cycle doorSen[0] pulse at cycle 0 -> motorOpen[0] cycles 1-3, doorOpen[0] cycles 4-8, motorClose[0] cycles 9-11, CLOSED from cycle 12; eventCnt=1; other doors idle.
- Door 1 in OPEN, doorSen[1] high again at hold-cycle 4 -> hold restarts, doorOpen[1] stays high 5 further cycles after sensor drops.
- Door 2 in CLOSING, obstruct[2]=1 on 2nd close cycle -> next cycle motorOpen[2]=1 for 3 cycles, then OPEN; eventCnt unchanged.
- lockReq[3]=1 with doorSen[3]=1 for 20 cycles -> door 3 stays CLOSED, eventCnt unchanged; drop lockReq -> opens next cycle.
- All four doorSen pulsed same cycle -> eventCnt +4, openCount=4 during cycles 4-8; rstN low at cycle 6 -> all outputs 0 immediately (asynchronously).
- DOOR_ALARM_EN, ALARM_CYCLES=32, obstruct[0] held high -> doorAlarm[0] sets after 32 non-CLOSED cycles, clears when door reaches CLOSED; without macro doorAlarm stays 0.
